reset_run_sequencer: RTL

- Synthesizable, parametrised successor to the bench-level "hold reset, release, run for a fixed time, finish" sequence.
- Sits beside `Top` as the single reset/run authority.
- Synchronises the board reset, then holds N downstream reset domains for a programmable time and releases them staggered.
- Then times a run window of RUN_CYCLES clocks and flags completion; supports restart, pause, free-run and counter-wrap indication.

---
 rtl/reset_run_pkg.sv | 18 +
 rtl/reset_sync.sv | 30 +++
 rtl/reset_run_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/reset_run_pkg.sv
// rtl/reset_run_pkg.sv - shared state encoding and sizing helpers for the reset/run sequencer
package reset_run_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  // The release counter only has to reach the last domain's release offset.
  function automatic int rc_width(input int n_domains, input int stagger);
    int span;
    span = (n_domains - 1) * stagger;
    return (span > 0) ? $clog2(span + 1) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - two-flop reset synchroniser, asynchronous assert and synchronous deassert
module reset_sync (
  input  logic clock,
  input  logic reset,
  output logic rst_n_s
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rst_n_s = sync_q;

endmodule

// File: rtl/reset_run_sequencer.sv
// rtl/reset_run_sequencer.sv - holds downstream reset domains, releases them staggered, then times a run window
module reset_run_sequencer
  import reset_run_pkg::*;
#(
  parameter int N_DOMAINS      = 3,
  parameter int RESET_CYCLES   = 2,
  parameter int STAGGER_CYCLES = 4,
  parameter int RUN_CYCLES     = 200,
  parameter int CNT_W          = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 pause,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 running,
  output logic                 done,
  output logic                 wrapped,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int RC_W = rc_width(N_DOMAINS, STAGGER_CYCLES);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam bit FREE_RUN = (RUN_CYCLES == 0);
  localparam bit ALL_AT_ONCE = ((N_DOMAINS - 1) * STAGGER_CYCLES == 0);

  if (N_DOMAINS < 1 || RESET_CYCLES < 1 || STAGGER_CYCLES < 0 || RUN_CYCLES < 0 ||
      CNT_W < 1 || CNT_W > 62 || longint'(RUN_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("reset_run_sequencer: illegal parameter combination");
  end

  logic rst_n_s;

  reset_sync u_reset_sync (
    .clock   (clock),
    .reset   (reset),
    .rst_n_s (rst_n_s)
  );

  seq_state_e           state_q,       state_d;
  logic [HC_W-1:0]      hc_q,          hc_d;
  logic [RC_W-1:0]      rc_q,          rc_d;
  logic [N_DOMAINS-1:0] domain_rst_q,  domain_rst_d;
  logic                 running_q,     running_d;
  logic                 done_q,        done_d;
  logic                 wrapped_q,     wrapped_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;

  logic [RC_W-1:0]      rc_inc;
  logic [N_DOMAINS-1:0] rel_mask;

  // Bit i is set once the release counter has reached domain i's offset.
  function automatic logic [N_DOMAINS-1:0] release_mask(input logic [RC_W-1:0] rc);
    logic [N_DOMAINS-1:0] m;
    m = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      m[i] = (rc >= RC_W'(i * STAGGER_CYCLES));
    end
    return m;
  endfunction

  assign rc_inc   = rc_q + RC_W'(1);
  assign rel_mask = release_mask(rc_inc);

  always_comb begin
    state_d       = state_q;
    hc_d          = hc_q;
    rc_d          = rc_q;
    domain_rst_d  = domain_rst_q;
    running_d     = running_q;
    done_d        = done_q;
    wrapped_d     = wrapped_q;
    cycle_count_d = cycle_count_q;

    if (restart) begin
      state_d       = HOLD;
      hc_d          = '0;
      rc_d          = '0;
      domain_rst_d  = '1;
      running_d     = 1'b0;
      done_d        = 1'b0;
      wrapped_d     = 1'b0;
      cycle_count_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hc_q == HC_LAST) begin
            // Domain 0 drops on this edge; with no stagger every domain does and RUN starts now.
            rc_d         = '0;
            domain_rst_d = ~release_mask('0);
            if (ALL_AT_ONCE) begin
              state_d       = RUN;
              running_d     = 1'b1;
              cycle_count_d = '0;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
        RELEASE: begin
          rc_d         = rc_inc;
          domain_rst_d = domain_rst_q & ~rel_mask;
          if (rel_mask[N_DOMAINS-1]) begin
            state_d       = RUN;
            running_d     = 1'b1;
            cycle_count_d = '0;
          end
        end
        RUN: begin
          if (!pause) begin
            if (!FREE_RUN && cycle_count_q == CNT_LAST) begin
              state_d   = DONE;
              running_d = 1'b0;
              done_d    = 1'b1;
            end else begin
              cycle_count_d = cycle_count_q + CNT_W'(1);
              if (FREE_RUN && cycle_count_q == '1) begin
                wrapped_d = 1'b1;
              end
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q       <= HOLD;
      hc_q          <= '0;
      rc_q          <= '0;
      domain_rst_q  <= '1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      wrapped_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      rc_q          <= rc_d;
      domain_rst_q  <= domain_rst_d;
      running_q     <= running_d;
      done_q        <= done_d;
      wrapped_q     <= wrapped_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign domain_rst  = domain_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign wrapped     = wrapped_q;
  assign cycle_count = cycle_count_q;

endmodule
